shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares the single 32-bit barrel shifter between two requesters: port 0 is the processor ALU path and port 1 is the plotter coprocessor.
- Each port issues shift requests on a valid/ready handshake.
- The block arbitrates between ports, drives the shared shifter's operand and shamt lines, registers the result, and returns it on one response channel tagged with the requester id.
- At most one result is outstanding at a time. Throughput is one shift per cycle when the response is consumed every cycle.

Parameters:
- WIDTH, 32, data width of operands and result.
- SHW, 5, shift-amount width.
- FIXED_PRI, 0: 0 selects round-robin arbitration; 1 makes port 0 always win.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous reset, active-low
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle
- req0_op  in  2  00=sll, 01=srl, 10=sra, 11=reserved
- req0_shamt  in  SHW  shift amount
- req0_data  in  WIDTH  operand
- req1_valid, req1_ready, req1_op, req1_shamt, req1_data: same as port 0, for port 1
- sh_op  out  2  to shared shifter: operation
- sh_shamt  out  SHW  to shared shifter: shift amount
- sh_in  out  WIDTH  to shared shifter: operand
- sh_out  in  WIDTH  combinational result from the shared shifter
- resp_valid  out  1  result held
- resp_ready  in  1  consumer accepts result
- resp_id  out  1  requester that owns the result
- resp_data  out  WIDTH  registered shift result
- resp_err  out  1  request used the reserved op

Behaviour:
- Reset (asynchronous, reset_n=0):
  - resp_valid=0, resp_id=0, resp_data=0, resp_err=0.
  - last_grant=1, so port 0 wins the first conflict.
  - A result held when reset asserts is discarded.
- States:
  - EMPTY (no result held) and FULL (result held).
  - EMPTY->FULL on grant.
  - FULL->EMPTY on resp_ready with no grant.
  - FULL->FULL on resp_ready with a grant in the same cycle (back-to-back).
  - FULL with resp_ready=0: hold; all outputs stable.
- can_accept = EMPTY, or (FULL and resp_ready).
- Grant rules, evaluated combinationally:
  - Only one requester valid: that port is granted if can_accept.
  - Both valid, round-robin: the port != last_grant wins.
  - Both valid, FIXED_PRI=1: port 0 wins.
  - reqN_ready = can_accept and port N wins. At most one ready per cycle.
  - A losing port keeps its request asserted and stable (requester rule).
- Shifter drive:
  - sh_op, sh_shamt and sh_in are muxed from the winning port.
  - With no grant they come from port 0 (don't-care, but deterministic).
  - Reserved op 11: drive sh_op=00 and sh_shamt=0, so data passes through unchanged.
- Capture, on the clock edge of a grant cycle:
  - resp_data <= sh_out
  - resp_id <= winner
  - resp_err <= (op==11)
  - last_grant <= winner
- Latency: request accepted in cycle N gives resp_valid=1 in cycle N+1.
- shamt is used modulo 2^SHW with no saturation. A shamt of 0 returns the operand unchanged for all ops.
- last_grant updates only on a grant; idle cycles leave it unchanged.
- resp_valid, resp_id and resp_data change only on the clock edge or async reset. No combinational path from req* to resp*.

Decomposition:
- Shared package: op encodings SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_RSV=2'b11; state encodings ST_EMPTY/ST_FULL.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with a fixed-priority override. It holds the last_grant flop and takes FIXED_PRI.
- The shifter itself stays outside this block.

Test Plan:
- Reset, then port 0 requests sll with shamt=4 and data=0x0000_00F1; resp_ready=1 -> cycle+1 gives resp_valid=1, resp_id=0, resp_data=0x0000_0F10, resp_err=0.
- Both ports valid every cycle (p0 srl 1 of 0x8000_0000, p1 sra 1 of 0x8000_0000), resp_ready=1 -> grants alternate 0,1,0,1. Results are 0x4000_0000 for p0 and 0xC000_0000 for p1, one per cycle.
- FIXED_PRI=1, both valid for 3 cycles -> req0_ready=1 and req1_ready=0 on all 3 cycles. Port 1 is granted only after req0_valid drops.
- Result held with resp_ready=0 for 4 cycles while port 1 requests -> req1_ready=0 throughout, and resp_data/resp_id stay stable. Raising resp_ready grants port 1 in that same cycle.
- Port 1 op=11, shamt=7, data=0x1234_5678 -> resp_data=0x1234_5678, resp_err=1, resp_id=1. The shifter sees sh_op=00 and sh_shamt=0.
- Assert reset_n=0 mid-cycle while FULL -> resp_valid drops immediately without a clock edge. After release, the next conflict is won by port 0.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// Shared encodings for the shift arbiter: shifter opcodes and response-slot states.
package shift_arbiter_pkg;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_RSV = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic logic isReserved(input logic [1:0] op);
        return (op == SH_RSV);
    endfunction

endpackage

// File: rtl/shift_arbiter_rr_arb2.sv
// Two-way round-robin grant with an optional fixed-priority override.
// Holds the last-grant flop; reset leaves it at 1 so port 0 wins the first conflict.
module rr_arb2 #(
    parameter int FIXED_PRI = 0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_enable,
    output logic o_grant,
    output logic o_winner
);

    logic r_lastGrant;
    logic w_winner;

    // With no request the winner defaults to port 0 so the shifter mux is deterministic
    always_comb begin
        w_winner = 1'b0;
        if (i_req0 && i_req1) begin
            w_winner = (FIXED_PRI != 0) ? 1'b0 : ~r_lastGrant;
        end else if (i_req1) begin
            w_winner = 1'b1;
        end
    end

    assign o_grant  = i_enable & (i_req0 | i_req1);
    assign o_winner = w_winner;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lastGrant <= 1'b1;
        end else if (o_grant) begin
            r_lastGrant <= w_winner;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Arbitrates two shift requesters onto one external barrel shifter and returns
// the registered result on a single response channel tagged with the requester id.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SHW       = 5,
    parameter int FIXED_PRI = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [SHW-1:0]   req1_shamt,
    input  logic [WIDTH-1:0] req1_data,
    output logic [1:0]       sh_op,
    output logic [SHW-1:0]   sh_shamt,
    output logic [WIDTH-1:0] sh_in,
    input  logic [WIDTH-1:0] sh_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err
);

    state_t           r_state;
    state_t           w_nextState;
    logic             r_respId;
    logic             r_respErr;
    logic [WIDTH-1:0] r_respData;

    logic             w_canAccept;
    logic             w_grant;
    logic             w_winner;
    logic             w_sel1;
    logic [1:0]       w_selOp;
    logic [SHW-1:0]   w_selShamt;
    logic [WIDTH-1:0] w_selData;

    assign w_canAccept = (r_state == ST_EMPTY) || resp_ready;

    rr_arb2 #(
        .FIXED_PRI(FIXED_PRI)
    ) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .i_req0  (req0_valid),
        .i_req1  (req1_valid),
        .i_enable(w_canAccept),
        .o_grant (w_grant),
        .o_winner(w_winner)
    );

    assign req0_ready = w_grant & ~w_winner;
    assign req1_ready = w_grant &  w_winner;
    assign w_sel1     = w_grant &  w_winner;

    always_comb begin
        w_selOp    = req0_op;
        w_selShamt = req0_shamt;
        w_selData  = req0_data;
        if (w_sel1) begin
            w_selOp    = req1_op;
            w_selShamt = req1_shamt;
            w_selData  = req1_data;
        end
    end

    // Reserved op turns into a zero-distance left shift, i.e. a pass-through
    always_comb begin
        sh_op    = w_selOp;
        sh_shamt = w_selShamt;
        sh_in    = w_selData;
        if (isReserved(w_selOp)) begin
            sh_op    = SH_SLL;
            sh_shamt = '0;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (w_grant) begin
            w_nextState = ST_FULL;
        end else if (resp_ready) begin
            w_nextState = ST_EMPTY;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Result slot loads only on a grant, so an unconsumed result stays frozen
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_respId   <= 1'b0;
            r_respErr  <= 1'b0;
            r_respData <= '0;
        end else if (w_grant) begin
            r_respId   <= w_winner;
            r_respErr  <= isReserved(w_selOp);
            r_respData <= sh_out;
        end
    end

    assign resp_valid = (r_state == ST_FULL);
    assign resp_id    = r_respId;
    assign resp_err   = r_respErr;
    assign resp_data  = r_respData;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: a round-robin instance is fully checked,
// a fixed-priority instance on the same inputs has its grants checked.
module tb_shift_arbiter;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef struct packed {
        logic        id;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_op, req1_op;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [31:0] req0_data, req1_data;
    logic        resp_ready;

    logic        d0_req0_ready, d0_req1_ready, d0_resp_valid, d0_resp_id, d0_resp_err;
    logic [1:0]  d0_sh_op;
    logic [4:0]  d0_sh_shamt;
    logic [31:0] d0_sh_in, d0_sh_out, d0_resp_data;

    logic        d1_req0_ready, d1_req1_ready, d1_resp_valid, d1_resp_id, d1_resp_err;
    logic [1:0]  d1_sh_op;
    logic [4:0]  d1_sh_shamt;
    logic [31:0] d1_sh_in, d1_sh_out, d1_resp_data;

    logic [31:0] expData0, expData1;
    logic        expErr0, expErr1;
    resp_t       sbQueue[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    // External shifter models feeding each instance
    function automatic logic [31:0] shiftModel(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] d);
        case (op)
            OP_SLL:  return d << sh;
            OP_SRL:  return d >> sh;
            OP_SRA:  return $unsigned($signed(d) >>> sh);
            default: return d;
        endcase
    endfunction

    assign d0_sh_out = shiftModel(d0_sh_op, d0_sh_shamt, d0_sh_in);
    assign d1_sh_out = shiftModel(d1_sh_op, d1_sh_shamt, d1_sh_in);

    shift_arbiter #(.WIDTH(32), .SHW(5), .FIXED_PRI(0)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(d0_req0_ready), .req0_op(req0_op),
        .req0_shamt(req0_shamt), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(d0_req1_ready), .req1_op(req1_op),
        .req1_shamt(req1_shamt), .req1_data(req1_data),
        .sh_op(d0_sh_op), .sh_shamt(d0_sh_shamt), .sh_in(d0_sh_in), .sh_out(d0_sh_out),
        .resp_valid(d0_resp_valid), .resp_ready(resp_ready), .resp_id(d0_resp_id),
        .resp_data(d0_resp_data), .resp_err(d0_resp_err)
    );

    shift_arbiter #(.WIDTH(32), .SHW(5), .FIXED_PRI(1)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(d1_req0_ready), .req0_op(req0_op),
        .req0_shamt(req0_shamt), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(d1_req1_ready), .req1_op(req1_op),
        .req1_shamt(req1_shamt), .req1_data(req1_data),
        .sh_op(d1_sh_op), .sh_shamt(d1_sh_shamt), .sh_in(d1_sh_in), .sh_out(d1_sh_out),
        .resp_valid(d1_resp_valid), .resp_ready(resp_ready), .resp_id(d1_resp_id),
        .resp_data(d1_resp_data), .resp_err(d1_resp_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic [1:0] op, input logic [4:0] sh,
                                 input logic [31:0] d, input logic [31:0] expD, input logic expE);
        if (port == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_shamt = sh; req0_data = d;
            expData0 = expD; expErr0 = expE;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_shamt = sh; req1_data = d;
            expData1 = expD; expErr1 = expE;
        end
    endtask

    // Scoreboard push on each accepted request of the round-robin instance
    always @(negedge clock) begin
        if (reset_n) begin
            if (req0_valid && d0_req0_ready) sbQueue.push_back('{1'b0, expErr0, expData0});
            if (req1_valid && d0_req1_ready) sbQueue.push_back('{1'b1, expErr1, expData1});
        end
    end

    // Monitor pops and compares whenever a result is handed over
    always @(negedge clock) begin
        resp_t exp;
        if (reset_n && d0_resp_valid && resp_ready) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL resp_unexpected: got id=%0d data=0x%0h, expected no result", d0_resp_id, d0_resp_data);
            end else begin
                exp = sbQueue.pop_front();
                checkOutput("resp", {29'b0, d0_resp_id, d0_resp_err, d0_resp_data}, {29'b0, exp.id, exp.err, exp.data});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    localparam int NVEC = 5;
    int          vecPort  [NVEC] = '{0, 1, 0, 1, 0};
    logic [1:0]  vecOp    [NVEC] = '{OP_SLL, OP_SRA, OP_SRA, OP_SRL, OP_SLL};
    logic [4:0]  vecShamt [NVEC] = '{5'd4, 5'd0, 5'd31, 5'd31, 5'd31};
    logic [31:0] vecData  [NVEC] = '{32'h0000_00F1, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0000_0003};
    logic [31:0] vecExp   [NVEC] = '{32'h0000_0F10, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000};

    initial begin
        reset_n = 1'b0;
        req0_valid = 0; req0_op = 0; req0_shamt = 0; req0_data = 0;
        req1_valid = 0; req1_op = 0; req1_shamt = 0; req1_data = 0;
        resp_ready = 0;
        expData0 = 0; expData1 = 0; expErr0 = 0; expErr1 = 0;

        #12;
        checkOutput("reset_valid", d0_resp_valid, 0);
        checkOutput("reset_id", d0_resp_id, 0);
        checkOutput("reset_data", d0_resp_data, 0);
        checkOutput("reset_err", d0_resp_err, 0);
        @(negedge clock); #3 reset_n = 1'b1;
        nextCycle();

        // Single-port vectors back to back, including shamt 0 and 31
        resp_ready = 1'b1;
        for (int k = 0; k < NVEC; k++) begin
            req0_valid = 0; req1_valid = 0;
            applyStimulus(vecPort[k], vecOp[k], vecShamt[k], vecData[k], vecExp[k], 1'b0);
            @(negedge clock);
            checkOutput("vec_ready", (vecPort[k] == 0) ? d0_req0_ready : d0_req1_ready, 1);
            if (k > 0) checkOutput("vec_latency_valid", d0_resp_valid, 1);
            nextCycle();
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clock);
        checkOutput("vec_last_valid", d0_resp_valid, 1);
        nextCycle();
        @(negedge clock);
        checkOutput("drain_empty", d0_resp_valid, 0);
        nextCycle();

        // Fresh reset so the first conflict goes to port 0
        reset_n = 1'b0;
        @(negedge clock); #3 reset_n = 1'b1;
        nextCycle();

        applyStimulus(0, OP_SRL, 5'd1, 32'h8000_0000, 32'h4000_0000, 1'b0);
        applyStimulus(1, OP_SRA, 5'd1, 32'h8000_0000, 32'hC000_0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checkOutput("rr_ready0", d0_req0_ready, (k % 2 == 0) ? 1 : 0);
            checkOutput("rr_ready1", d0_req1_ready, (k % 2 == 1) ? 1 : 0);
            if (k < 3) begin
                checkOutput("fixed_ready0", d1_req0_ready, 1);
                checkOutput("fixed_ready1", d1_req1_ready, 0);
            end
            nextCycle();
        end
        req0_valid = 0;
        @(negedge clock);
        checkOutput("fixed_p1_after_drop", d1_req1_ready, 1);
        checkOutput("rr_p1_alone", d0_req1_ready, 1);
        nextCycle();
        req1_valid = 0;
        @(negedge clock);
        nextCycle();

        // Result held with resp_ready low while port 1 waits
        resp_ready = 1'b0;
        applyStimulus(0, OP_SRL, 5'd1, 32'h8000_0000, 32'h4000_0000, 1'b0);
        @(negedge clock);
        checkOutput("hold_accept0", d0_req0_ready, 1);
        nextCycle();
        req0_valid = 0;
        applyStimulus(1, OP_SLL, 5'd8, 32'h0000_0012, 32'h0000_1200, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checkOutput("hold_ready1", d0_req1_ready, 0);
            checkOutput("hold_valid", d0_resp_valid, 1);
            checkOutput("hold_data", d0_resp_data, 32'h4000_0000);
            checkOutput("hold_id", d0_resp_id, 0);
            nextCycle();
        end
        resp_ready = 1'b1;
        @(negedge clock);
        checkOutput("release_ready1", d0_req1_ready, 1);
        nextCycle();
        req1_valid = 0;
        @(negedge clock);
        nextCycle();

        // Reserved op passes data through and flags an error
        applyStimulus(1, OP_RSV, 5'd7, 32'h1234_5678, 32'h1234_5678, 1'b1);
        @(negedge clock);
        checkOutput("rsv_ready1", d0_req1_ready, 1);
        checkOutput("rsv_sh_op", d0_sh_op, 0);
        checkOutput("rsv_sh_shamt", d0_sh_shamt, 0);
        checkOutput("rsv_sh_in", d0_sh_in, 32'h1234_5678);
        nextCycle();
        req1_valid = 0;
        @(negedge clock);
        nextCycle();

        // Asynchronous reset while a result is held
        resp_ready = 1'b0;
        applyStimulus(0, OP_SLL, 5'd0, 32'h0000_00A5, 32'h0000_00A5, 1'b0);
        @(negedge clock);
        nextCycle();
        req0_valid = 0;
        checkOutput("full_before_reset", d0_resp_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", d0_resp_valid, 0);
        checkOutput("async_reset_data", d0_resp_data, 0);
        sbQueue.delete();
        @(negedge clock); #3 reset_n = 1'b1;
        nextCycle();
        resp_ready = 1'b1;
        applyStimulus(0, OP_SRL, 5'd4, 32'h0000_00F0, 32'h0000_000F, 1'b0);
        applyStimulus(1, OP_SLL, 5'd1, 32'h0000_0001, 32'h0000_0002, 1'b0);
        @(negedge clock);
        checkOutput("post_reset_ready0", d0_req0_ready, 1);
        checkOutput("post_reset_ready1", d0_req1_ready, 0);
        nextCycle();
        req0_valid = 0; req1_valid = 0;
        @(negedge clock);
        nextCycle();
        @(negedge clock);
        checkOutput("scoreboard_empty", sbQueue.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
